// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants, op typedef and datapath width.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'd0;
  localparam alu_op_t ALU_LUI  = 4'd1;
  localparam alu_op_t ALU_SUB  = 4'd2;
  localparam alu_op_t ALU_SLT  = 4'd3;
  localparam alu_op_t ALU_SLTU = 4'd4;
  localparam alu_op_t ALU_AND  = 4'd5;
  localparam alu_op_t ALU_OR   = 4'd6;
  localparam alu_op_t ALU_XOR  = 4'd7;
  localparam alu_op_t ALU_NOR  = 4'd8;
  localparam alu_op_t ALU_SLL  = 4'd9;
  localparam alu_op_t ALU_SRL  = 4'd10;
  localparam alu_op_t ALU_SRA  = 4'd11;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; shifts move src2 by src1[4:0], unused codes yield 0.
module alu
  import alu_pkg::*;
(
  input  alu_op_t          ALUControl,
  input  logic [ALU_W-1:0] alu_src1,
  input  logic [ALU_W-1:0] alu_src2,
  output logic [ALU_W-1:0] alu_result
);

  logic signed [ALU_W-1:0] src1_s;
  logic signed [ALU_W-1:0] src2_s;
  logic        [4:0]       shamt;

  assign src1_s = alu_src1;
  assign src2_s = alu_src2;
  assign shamt  = alu_src1[4:0];

  always_comb begin
    alu_result = '0;
    case (ALUControl)
      ALU_ADD:  alu_result = alu_src1 + alu_src2;
      ALU_LUI:  alu_result = {alu_src2[15:0], 16'h0000};
      ALU_SUB:  alu_result = alu_src1 - alu_src2;
      ALU_SLT:  alu_result = {{(ALU_W-1){1'b0}}, (src1_s < src2_s)};
      ALU_SLTU: alu_result = {{(ALU_W-1){1'b0}}, (alu_src1 < alu_src2)};
      ALU_AND:  alu_result = alu_src1 & alu_src2;
      ALU_OR:   alu_result = alu_src1 | alu_src2;
      ALU_XOR:  alu_result = alu_src1 ^ alu_src2;
      ALU_NOR:  alu_result = ~(alu_src1 | alu_src2);
      ALU_SLL:  alu_result = alu_src2 << shamt;
      ALU_SRL:  alu_result = alu_src2 >> shamt;
      ALU_SRA:  alu_result = src2_s >>> shamt;
      default:  alu_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one ALU between two ports with one-entry response regs.
// Define ALU_ARB_FIXED_PRIO_EN to make port 0 always win contention.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [3:0]   req_op0,
  input  logic [3:0]   req_op1,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_b1,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [W-1:0] rsp_data0,
  output logic [W-1:0] rsp_data1,
  output logic         last_grant
);

  if (W != ALU_W) begin : g_w_check
    $error("alu_share_arb: W must equal ALU_W (32)");
  end

  logic [1:0]   rsp_valid_q, rsp_valid_d;
  logic [W-1:0] rsp_data0_q, rsp_data0_d;
  logic [W-1:0] rsp_data1_q, rsp_data1_d;
  logic         last_grant_q, last_grant_d;

  logic [1:0]   elig;
  logic [1:0]   grant;
  alu_op_t      alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_y;

  // A port with a pending response may still be granted when that response drains this cycle.
  always_comb begin
    elig  = req_valid & (~rsp_valid_q | rsp_ready);
    grant = 2'b00;
    if (resetn) begin
      if (elig == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant = 2'b01;
`else
        grant = last_grant_q ? 2'b01 : 2'b10;
`endif
      end else begin
        grant = elig;
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    alu_op = req_op0;
    alu_a  = req_a0;
    alu_b  = req_b0;
    if (grant[1]) begin
      alu_op = req_op1;
      alu_a  = req_a1;
      alu_b  = req_b1;
    end
  end

  alu u_alu (
    .ALUControl (alu_op),
    .alu_src1   (alu_a),
    .alu_src2   (alu_b),
    .alu_result (alu_y)
  );

  // A new accept overrides a same-cycle drain, so valid stays high with fresh data.
  always_comb begin
    rsp_valid_d  = rsp_valid_q & ~rsp_ready;
    rsp_valid_d  = rsp_valid_d | grant;
    rsp_data0_d  = grant[0] ? alu_y : rsp_data0_q;
    rsp_data1_d  = grant[1] ? alu_y : rsp_data1_q;
    last_grant_d = (grant != 2'b00) ? grant[1] : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_valid_q  <= 2'b00;
      rsp_data0_q  <= '0;
      rsp_data1_q  <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_data0_q  <= rsp_data0_d;
      rsp_data1_q  <= rsp_data1_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data0  = rsp_data0_q;
  assign rsp_data1  = rsp_data1_q;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: a reference model predicts grants and results.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1, rsp_data0, rsp_data1;
  logic        last_grant;

  alu_share_arb #(.W(32)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [1:0]  m_vld;
  logic        m_last;
  logic [1:0]  exp_rdy;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] exp_d;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  s;
    logic [31:0] r;
    s = a[4:0];
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = b << 16;
      4'd2:  r = a + (~b) + 32'd1;
      4'd3:  r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4'd4:  r = {31'd0, (a < b)};
      4'd5:  r = a & b;
      4'd6:  r = a | b;
      4'd7:  r = a ^ b;
      4'd8:  r = ~a & ~b;
      4'd9:  r = b << s;
      4'd10: r = b >> s;
      4'd11: r = (b >> s) | (b[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic apply(input logic [1:0] v,
                       input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic [1:0] rr);
    logic e0, e1;
    req_valid = v; rsp_ready = rr;
    req_op0 = o0; req_a0 = a0; req_b0 = b0;
    req_op1 = o1; req_a1 = a1; req_b1 = b1;
    e0 = v[0] && (!m_vld[0] || rr[0]);
    e1 = v[1] && (!m_vld[1] || rr[1]);
    if (!resetn) exp_rdy = 2'b00;
`ifdef ALU_ARB_FIXED_PRIO_EN
    else if (e0 && e1) exp_rdy = 2'b01;
`else
    else if (e0 && e1) exp_rdy = m_last ? 2'b01 : 2'b10;
`endif
    else exp_rdy = {e1, e0};
    #1;
  endtask

  task automatic advance();
    if (exp_rdy[0]) q0.push_back(ref_alu(req_op0, req_a0, req_b0));
    if (exp_rdy[1]) q1.push_back(ref_alu(req_op1, req_a1, req_b1));
    for (int p = 0; p < 2; p++)
      m_vld[p] = exp_rdy[p] | (m_vld[p] & ~rsp_ready[p]);
    if (exp_rdy != 2'b00) m_last = exp_rdy[1];
    if (!resetn) begin
      m_vld = 2'b00; m_last = 1'b1; q0.delete(); q1.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    apply(2'b11, 4'd0, 32'd1, 32'd1, 4'd0, 32'd2, 32'd2, 2'b11);
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_rdy got=%b exp=00", req_ready); end
    advance();
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_vld got=%b exp=00", rsp_valid); end
    checks++; if (rsp_data0 !== 32'd0) begin failures++; $display("FAIL reset_d0 got=%h exp=0", rsp_data0); end
    checks++; if (rsp_data1 !== 32'd0) begin failures++; $display("FAIL reset_d1 got=%h exp=0", rsp_data1); end
    checks++; if (last_grant !== 1'b1) begin failures++; $display("FAIL reset_lg got=%b exp=1", last_grant); end
    resetn = 1'b1;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 5; i++) begin
      apply((i < 4) ? 2'b11 : 2'b00, 4'd3, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'hFFFF_FFFF, 32'd1, 2'b11);
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rr_rdy cyc=%0d got=%b exp=%b", i, req_ready, exp_rdy); end
      if (i < 4) begin
        checks++;
        if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin failures++; $display("FAIL rr_alt cyc=%0d got=%b", i, req_ready); end
      end
      checks++; if (rsp_valid !== m_vld) begin failures++; $display("FAIL rr_vld cyc=%0d got=%b exp=%b", i, rsp_valid, m_vld); end
      if (m_vld[0] && rsp_ready[0]) begin
        exp_d = q0.pop_front();
        checks++; if (rsp_data0 !== exp_d || rsp_data0 !== 32'd1) begin failures++; $display("FAIL rr_slt got=%h exp=%h", rsp_data0, exp_d); end
      end
      if (m_vld[1] && rsp_ready[1]) begin
        exp_d = q1.pop_front();
        checks++; if (rsp_data1 !== exp_d || rsp_data1 !== 32'd0) begin failures++; $display("FAIL rr_sltu got=%h exp=%h", rsp_data1, exp_d); end
      end
      advance();
    end
  endtask

  task automatic test_add_sub();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: apply(2'b01, 4'd0, 32'd5, 32'd3, 4'd0, 32'd0, 32'd0, 2'b11);
        1: apply(2'b01, 4'd2, 32'd3, 32'd5, 4'd0, 32'd0, 32'd0, 2'b11);
        default: apply(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 2'b11);
      endcase
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL as_rdy cyc=%0d got=%b exp=%b", i, req_ready, exp_rdy); end
      checks++; if (rsp_valid !== m_vld) begin failures++; $display("FAIL as_vld cyc=%0d got=%b exp=%b", i, rsp_valid, m_vld); end
      if (m_vld[0] && rsp_ready[0]) begin
        exp_d = q0.pop_front();
        checks++;
        if (rsp_data0 !== exp_d || rsp_data0 !== ((i == 1) ? 32'h8 : 32'hFFFF_FFFE)) begin
          failures++; $display("FAIL as_data cyc=%0d got=%h exp=%h", i, rsp_data0, exp_d);
        end
      end
      advance();
    end
    checks++; if (last_grant !== 1'b0) begin failures++; $display("FAIL as_lg got=%b exp=0", last_grant); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      apply(2'b01, 4'd0, 32'd1, 32'd2, 4'd11, 32'd4, 32'h8000_0000, 2'b00);
      else if (i < 5)  apply(2'b11, 4'd0, 32'd7, 32'd7, 4'd11, 32'd4, 32'h8000_0000, 2'b10);
      else if (i == 5) apply(2'b11, 4'd0, 32'd7, 32'd7, 4'd11, 32'd4, 32'h8000_0000, 2'b11);
      else             apply(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 2'b11);
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL bp_rdy cyc=%0d got=%b exp=%b", i, req_ready, exp_rdy); end
      if (i >= 1 && i <= 4) begin
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_p1only cyc=%0d got=%b", i, req_ready); end
      end
      if (i == 5) begin
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_release got=%b exp=01", req_ready); end
      end
      checks++; if (rsp_valid !== m_vld) begin failures++; $display("FAIL bp_vld cyc=%0d got=%b exp=%b", i, rsp_valid, m_vld); end
      if (m_vld[0] && rsp_ready[0]) begin
        exp_d = q0.pop_front();
        checks++; if (rsp_data0 !== exp_d) begin failures++; $display("FAIL bp_d0 cyc=%0d got=%h exp=%h", i, rsp_data0, exp_d); end
      end
      if (m_vld[1] && rsp_ready[1]) begin
        exp_d = q1.pop_front();
        checks++; if (rsp_data1 !== exp_d || rsp_data1 !== 32'hF800_0000) begin failures++; $display("FAIL bp_sra cyc=%0d got=%h exp=%h", i, rsp_data1, exp_d); end
      end
      advance();
    end
  endtask

  task automatic test_lui_and_random();
    logic [3:0] o0, o1;
    for (int i = 0; i < 45; i++) begin
      o0 = 4'($urandom_range(0, 15));
      o1 = 4'($urandom_range(0, 15));
      if (i == 0)      apply(2'b10, 4'd0, 32'd0, 32'd0, 4'd1, 32'd0, 32'h0000_1234, 2'b11);
      else if (i == 1) apply(2'b01, 4'd13, 32'hDEAD_BEEF, 32'h1234_5678, 4'd0, 32'd0, 32'd0, 2'b11);
      else if (i < 42) apply(2'($urandom), o0, $urandom, $urandom, o1, $urandom, $urandom, 2'($urandom));
      else             apply(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 2'b11);
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rnd_rdy cyc=%0d got=%b exp=%b", i, req_ready, exp_rdy); end
      checks++; if (rsp_valid !== m_vld) begin failures++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", i, rsp_valid, m_vld); end
      checks++; if (last_grant !== m_last) begin failures++; $display("FAIL rnd_lg cyc=%0d got=%b exp=%b", i, last_grant, m_last); end
      if (i == 1) begin
        checks++; if (rsp_data1 !== 32'h1234_0000) begin failures++; $display("FAIL lui got=%h exp=12340000", rsp_data1); end
      end
      if (i == 2) begin
        checks++; if (rsp_data0 !== 32'h0) begin failures++; $display("FAIL op13 got=%h exp=0", rsp_data0); end
      end
      if (m_vld[0] && rsp_ready[0]) begin
        exp_d = q0.pop_front();
        checks++; if (rsp_data0 !== exp_d) begin failures++; $display("FAIL rnd_d0 cyc=%0d got=%h exp=%h", i, rsp_data0, exp_d); end
      end
      if (m_vld[1] && rsp_ready[1]) begin
        exp_d = q1.pop_front();
        checks++; if (rsp_data1 !== exp_d) begin failures++; $display("FAIL rnd_d1 cyc=%0d got=%h exp=%h", i, rsp_data1, exp_d); end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      apply(2'b11, 4'd0, 32'd1, 32'd1, 4'd0, 32'd2, 32'd2, 2'b00);
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rm_rdy cyc=%0d got=%b exp=%b", i, req_ready, exp_rdy); end
      advance();
    end
    checks++; if (rsp_valid !== 2'b11) begin failures++; $display("FAIL rm_pend got=%b exp=11", rsp_valid); end
    resetn = 1'b0;
    apply(2'b11, 4'd0, 32'd1, 32'd1, 4'd0, 32'd2, 32'd2, 2'b00);
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rm_rdy_rst got=%b exp=00", req_ready); end
    advance();
    resetn = 1'b1;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rm_vld got=%b exp=00", rsp_valid); end
    checks++; if (last_grant !== 1'b1) begin failures++; $display("FAIL rm_lg got=%b exp=1", last_grant); end
    for (int i = 0; i < 3; i++) begin
      apply((i == 0) ? 2'b11 : 2'b00, 4'd7, 32'hF0F0_F0F0, 32'hFFFF_0000, 4'd8, 32'd1, 32'd2, 2'b11);
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rm2_rdy cyc=%0d got=%b exp=%b", i, req_ready, exp_rdy); end
      if (i == 0) begin
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rm_first got=%b exp=01", req_ready); end
      end
      checks++; if (rsp_valid !== m_vld) begin failures++; $display("FAIL rm2_vld cyc=%0d got=%b exp=%b", i, rsp_valid, m_vld); end
      if (m_vld[0] && rsp_ready[0]) begin
        exp_d = q0.pop_front();
        checks++; if (rsp_data0 !== exp_d) begin failures++; $display("FAIL rm2_d0 got=%h exp=%h", rsp_data0, exp_d); end
      end
      advance();
    end
  endtask

`ifdef ALU_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    for (int i = 0; i < 5; i++) begin
      apply((i < 4) ? 2'b11 : 2'b00, 4'd6, 32'd1, 32'd2, 4'd5, 32'd3, 32'd6, 2'b11);
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL fp_rdy cyc=%0d got=%b exp=%b", i, req_ready, exp_rdy); end
      if (i < 4) begin
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL fp_p0 cyc=%0d got=%b exp=01", i, req_ready); end
      end
      if (m_vld[0] && rsp_ready[0]) begin
        exp_d = q0.pop_front();
        checks++; if (rsp_data0 !== exp_d) begin failures++; $display("FAIL fp_d0 got=%h exp=%h", rsp_data0, exp_d); end
      end
      advance();
    end
  endtask
`endif

  initial begin
    resetn = 1'b0; m_vld = 2'b00; m_last = 1'b1; exp_rdy = 2'b00;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_op0 = 4'd0; req_op1 = 4'd0;
    req_a0 = 32'd0; req_a1 = 32'd0; req_b0 = 32'd0; req_b1 = 32'd0;
    test_reset();
    test_round_robin();
    test_add_sub();
    test_backpressure();
    test_lui_and_random();
    test_reset_mid();
`ifdef ALU_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter that shares one combinational ALU between two requesters, e.g. the execute stage and a branch/address-compute unit. Each port has a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin and drives the shared ALU for the granted port. The result is captured into that port's one-entry response register, so each accepted operation completes in exactly one cycle.

## Interface
- `W`, default 32: operand and result width; the ALU is fixed at 32, so any other value is a compile-time error.
- `clk`  in  1  clock; all state updates on its rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `req_valid[1:0]`  in  2  per-port request valid.
- `req_ready[1:0]`  out  2  per-port request ready; a request is accepted when valid and ready are both high.
- `req_op0`, `req_op1`  in  4 each  ALU op code for port 0 / port 1.
- `req_a0`, `req_a1`  in  32 each  source 1 (shift amount taken from bits 4:0).
- `req_b0`, `req_b1`  in  32 each  source 2.
- `rsp_valid[1:0]`  out  2  per-port response valid.
- `rsp_ready[1:0]`  in  2  per-port response ready.
- `rsp_data0`, `rsp_data1`  out  32 each  registered ALU result.
- `last_grant`  out  1  port granted most recently (debug/observability).

## Operation
- Op codes: 0 ADD, 1 LUI, 2 SUB, 3 SLT, 4 SLTU, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLL, 10 SRL, 11 SRA. Codes 12–15 produce 0.
- Arithmetic is 32-bit with wrap-around and no overflow trap. SLT and SLTU return 0 or 1 in bit 0. LUI returns `{b[15:0],16'b0}`. Shifts shift b by a[4:0].
- Port p is eligible when `req_valid[p]` is high and either `rsp_valid[p]` is low or `rsp_ready[p]` is high in the same cycle (pass-through drain).
- Grant rules:
  - Exactly one eligible port: that port is granted.
  - Both eligible: the port not equal to `last_grant` is granted.
  - `req_ready[p]` is high only for the granted port.
- `req_ready` depends combinationally on `req_valid` of both ports and on `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- On accept at port p:
  - The ALU evaluates port p's operands.
  - `rsp_data_p` is loaded and `rsp_valid[p]` is set.
  - `last_grant` is set to p.
- `last_grant` holds when nothing is granted.
- A response clears when `rsp_valid[p]` and `rsp_ready[p]` are both high and no new accept for p occurs in that cycle. If a new accept does occur in that cycle, `rsp_valid[p]` stays high and the data is replaced.
- `rsp_data_p` holds its value while `rsp_valid[p]` is low.
- The shared ALU is the only arithmetic resource; at most one operation is accepted per cycle across both ports.

## Timing
- Latency: accepted in cycle N, so `rsp_valid` is high and data is valid in cycle N+1.
- Throughput: one operation per cycle in aggregate. A single port sustains one per cycle if its `rsp_ready` stays high.
- Reset state (`resetn` low at a clock edge): `rsp_valid` = 0, `rsp_data0/1` = 0, `last_grant` = 1, so port 0 wins the first contention.
- Reset mid-operation: pending responses are discarded. Requests presented during reset are not accepted (`req_ready` = 0 while `resetn` is low).
- Backpressure: when `rsp_valid[p]` = 1 and `rsp_ready[p]` = 0, port p is ineligible. The other port can still be granted every cycle.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined:
  - Port 0 always wins contention.
  - `last_grant` still tracks grants but does not affect arbitration.
  - Port 1 can starve.
- Undefined (default): round-robin as described under Operation.

## Structure
- Shared package `alu_pkg`:
  - Op-code constants (`ALU_ADD` … `ALU_SRA`) and the 4-bit op typedef, shared with the decoder.
  - The width constant, 32.
- One sub-module, `alu`: the existing combinational ALU with ports ALUControl, alu_src1, alu_src2, alu_result, instantiated once behind an operand mux.
- Arbitration, the response registers and `last_grant` live in the top module.

## Test plan
- Port 0 only, ADD a=5 b=3 -> `rsp_valid[0]` high next cycle, `rsp_data0` = 0x00000008. Also SUB a=3 b=5 -> 0xFFFFFFFE.
- Both ports valid every cycle, `rsp_ready` = 2'b11, port 0 SLT a=0xFFFFFFFF b=1 and port 1 SLTU with the same operands -> grants alternate 0,1,0,1. `rsp_data0` = 1, `rsp_data1` = 0.
- Port 0 `rsp_ready` held low with a response pending, port 1 streaming SRA a=4 b=0x80000000 -> port 0 not granted, port 1 granted every cycle with data 0xF8000000. Releasing `rsp_ready[0]` lets port 0 be accepted in that same cycle.
- LUI b=0x00001234 and op 13 -> 0x12340000 and 0x00000000 respectively.
- Assert `resetn` low for one cycle while both responses are pending -> `rsp_valid` = 0, `last_grant` = 1, and the next contention is won by port 0.
- With `ALU_ARB_FIXED_PRIO_EN` defined, both ports valid for 4 cycles -> port 0 is granted all 4 cycles and port 1 `req_ready` stays 0.
